// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch and loader bundle of the instruction memory.
// master = CPU fetch stage plus program loader, slave = imem_sync.
interface imem_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              addr_err;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;

  modport master (
    input  ready, fetch_valid, fetch_data,
    input  addr_err, ld_ready, ld_done,
    output fetch_req, fetch_addr, stall,
    output ld_start, ld_base, ld_len,
    output ld_valid, ld_data
  );

  modport slave (
    output ready, fetch_valid, fetch_data,
    output addr_err, ld_ready, ld_done,
    input  fetch_req, fetch_addr, stall,
    input  ld_start, ld_base, ld_len,
    input  ld_valid, ld_data
  );
endinterface

// File: rtl/imem_sync.sv
// imem_sync: loadable synchronous instruction memory.
// NOP sweep after reset, 1-cycle registered fetch, streamed loader.
module imem_sync #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic       clk,
  input logic       rst_n,
  imem_sync_if.slave bus
);
  localparam int IW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);
  localparam logic [IW-1:0] LAST =
    IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR, RUN, LOAD
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO, SRC_MEM, SRC_NOP
  } src_t;

  state_t          state, state_nx;
  src_t            src, src_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [ADDR_W:0] cnt, cnt_nx;
  logic            fv, fv_nx;
  logic            err, err_nx;
  logic            done, done_nx;

  logic              we, re;
  logic [IW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          oob, take;
  logic [IW-1:0] ptr_inc, base_mod;

  assign oob  = {1'b0, bus.fetch_addr} >= DEPTH_L;
  assign take = bus.ld_valid && bus.ld_ready;

  // one pointer serves the sweep and the loader;
  // both wrap at DEPTH, not at 2**ADDR_W
  assign ptr_inc  = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign base_mod =
    IW'({1'b0, bus.ld_base} % DEPTH_L);

  always_comb begin
    state_nx = state;
    src_nx   = src;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    fv_nx    = fv;
    err_nx   = err;
    done_nx  = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    waddr    = ptr;
    wdata    = NOP_WORD;
    raddr    = IW'(bus.fetch_addr);
    unique case (state)
      CLEAR: begin
        we     = 1'b1;
        ptr_nx = ptr_inc;
        if (ptr == LAST) state_nx = RUN;
      end
      RUN: begin
        if (!bus.stall) begin
          if (bus.ld_start) begin
            state_nx = LOAD;
            ptr_nx   = base_mod;
            cnt_nx   = bus.ld_len;
            fv_nx    = 1'b0;
            err_nx   = 1'b0;
            done_nx  = (bus.ld_len == '0);
          end else if (bus.fetch_req) begin
            fv_nx  = 1'b1;
            err_nx = oob;
            re     = !oob;
            src_nx = oob ? SRC_NOP : SRC_MEM;
          end else begin
            fv_nx  = 1'b0;
            err_nx = 1'b0;
          end
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          state_nx = RUN;
        end else if (take) begin
          we     = 1'b1;
          wdata  = bus.ld_data;
          ptr_nx = ptr_inc;
          cnt_nx = cnt - 1'b1;
          if (cnt == 1) begin
            state_nx = RUN;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      src   <= SRC_ZERO;
      ptr   <= '0;
      cnt   <= '0;
      fv    <= 1'b0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      src   <= src_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      fv    <= fv_nx;
      err   <= err_nx;
      done  <= done_nx;
    end
  end

  // plain single-port RAM, no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

  assign bus.ready       = (state == RUN);
  assign bus.ld_ready    = (state == LOAD) && (cnt != '0);
  assign bus.ld_done     = done;
  assign bus.fetch_valid = fv;
  assign bus.addr_err    = err;
  assign bus.fetch_data  =
    (src == SRC_MEM) ? rdata :
    (src == SRC_NOP) ? NOP_WORD : '0;
endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: scoreboard bench, DEPTH=256 random plus
// a DEPTH=200 instance for range and wrap corners.
module tb_imem_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  imem_sync_if #(.DATA_W(16), .ADDR_W(8)) a ();
  imem_sync_if #(.DATA_W(16), .ADDR_W(8)) b ();

  imem_sync #(
    .DATA_W(16), .ADDR_W(8),
    .DEPTH(256), .NOP_WORD(16'h0000)
  ) dut_a (.clk(clk), .rst_n(rst_a), .bus(a));

  imem_sync #(
    .DATA_W(16), .ADDR_W(8),
    .DEPTH(200), .NOP_WORD(16'h0000)
  ) dut_b (.clk(clk), .rst_n(rst_b), .bus(b));

  int checks = 0;
  int failures = 0;
  bit done_a = 0;
  bit done_b = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t        q[$];
  exp_t        last_e;
  logic [15:0] model [256];
  logic        prev_stall = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops one expectation per new fetch word
  always @(posedge clk) prev_stall <= a.stall;

  always @(negedge clk) begin
    if (rst_a && a.fetch_valid) begin
      if (prev_stall) begin
        check("held_data", 32'(a.fetch_data),
              32'(last_e.d));
        check("held_err", 32'(a.addr_err),
              32'(last_e.e));
      end else if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid got=1 exp=0");
      end else begin
        last_e = q.pop_front();
        check("fetch_data", 32'(a.fetch_data),
              32'(last_e.d));
        check("addr_err", 32'(a.addr_err),
              32'(last_e.e));
      end
    end
  end

  task automatic idle_a();
    a.fetch_req = 0; a.fetch_addr = '0;
    a.stall = 0; a.ld_start = 0;
    a.ld_base = '0; a.ld_len = '0;
    a.ld_valid = 0; a.ld_data = '0;
  endtask

  task automatic idle_b();
    b.fetch_req = 0; b.fetch_addr = '0;
    b.stall = 0; b.ld_start = 0;
    b.ld_base = '0; b.ld_len = '0;
    b.ld_valid = 0; b.ld_data = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  task automatic rst_outs_a();
    check("rst_ready", 32'(a.ready), 0);
    check("rst_fv", 32'(a.fetch_valid), 0);
    check("rst_fd", 32'(a.fetch_data), 0);
    check("rst_err", 32'(a.addr_err), 0);
    check("rst_ldr", 32'(a.ld_ready), 0);
    check("rst_ldd", 32'(a.ld_done), 0);
  endtask

  task automatic wait_ready_a(input int exp_n);
    int n = 0;
    while (!a.ready && n < 400) begin
      tick();
      n++;
    end
    check("sweep_a", n, exp_n);
  endtask

  task automatic fetch_a(input logic [7:0] ad);
    a.fetch_req = 1;
    a.fetch_addr = ad;
    q.push_back('{model[ad], 1'b0});
    tick();
    a.fetch_req = 0;
    check("fetch_lat", 32'(a.fetch_valid), 1);
  endtask

  task automatic load_a(input logic [7:0] base,
                        input logic [15:0] w[$],
                        input int gmax,
                        input bit rnd);
    int len = w.size();
    a.ld_start = 1;
    a.ld_base = base;
    a.ld_len = 9'(len);
    tick();
    a.ld_start = 0;
    check("load_enter", 32'(a.ready), 0);
    if (len == 0) begin
      check("len0_done", 32'(a.ld_done), 1);
      tick();
      check("len0_ready", 32'(a.ready), 1);
      check("len0_pulse", 32'(a.ld_done), 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      int g = rnd ? $urandom_range(0, gmax) : gmax;
      model[8'(base + i)] = w[i];
      a.ld_valid = 0;
      repeat (g) tick();
      check("ld_ready", 32'(a.ld_ready), 1);
      a.ld_valid = 1;
      a.ld_data = w[i];
      tick();
    end
    a.ld_valid = 0;
    check("ld_done", 32'(a.ld_done), 1);
    check("ld_back", 32'(a.ready), 1);
    check("ld_rdy_lo", 32'(a.ld_ready), 0);
    tick();
    check("ld_pulse", 32'(a.ld_done), 0);
  endtask

  initial begin
    logic [15:0] w[$];
    idle_a();
    model_clear();
    #2 rst_a = 0;
    #10 rst_outs_a();
    @(negedge clk) rst_a = 1;
    wait_ready_a(256);

    fetch_a(8'h00);
    fetch_a(8'h7F);
    fetch_a(8'hFF);
    tick();
    check("idle_fv", 32'(a.fetch_valid), 0);

    w = '{16'hF800, 16'hC801, 16'hD002, 16'hD803};
    load_a(8'h10, w, 1, 0);
    for (int i = 0; i < 4; i++) fetch_a(8'(8'h10 + i));

    w = '{16'(($urandom)), 16'(($urandom)),
          16'(($urandom))};
    load_a(8'hFE, w, 0, 0);
    fetch_a(8'hFE);
    fetch_a(8'hFF);
    fetch_a(8'h00);
    fetch_a(8'h01);
    check("wrap_keep", 32'(model[1]), 0);

    fetch_a(8'h10);
    a.stall = 1;
    a.fetch_req = 1;
    a.fetch_addr = 8'h11;
    repeat (3) begin
      tick();
      check("stall_fv", 32'(a.fetch_valid), 1);
      check("stall_fd", 32'(a.fetch_data), 32'hF800);
    end
    a.stall = 0;
    q.push_back('{model[8'h11], 1'b0});
    tick();
    a.fetch_req = 0;
    check("unstall_fd", 32'(a.fetch_data), 32'hC801);

    repeat (400) begin
      int r = $urandom_range(0, 99);
      if (r < 50) begin
        fetch_a(8'($urandom));
      end else if (r < 70) begin
        a.stall = 1;
        a.fetch_req = 1'($urandom);
        a.fetch_addr = 8'($urandom);
        tick();
        a.stall = 0;
        a.fetch_req = 0;
      end else if (r < 76) begin
        int n = ($urandom_range(0, 7) == 0) ?
                $urandom_range(250, 300) :
                $urandom_range(0, 10);
        w.delete();
        for (int i = 0; i < n; i++)
          w.push_back(16'($urandom));
        load_a(8'($urandom), w, 2, 1);
      end else begin
        tick();
      end
    end
    tick();
    tick();
    check("queue_empty", q.size(), 0);

    w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    a.ld_start = 1;
    a.ld_base = 8'h20;
    a.ld_len = 9'd4;
    tick();
    a.ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      a.ld_valid = 1;
      a.ld_data = w[i];
      tick();
    end
    rst_a = 0;
    idle_a();
    #1 rst_outs_a();
    model_clear();
    repeat (2) @(negedge clk);
    rst_a = 1;
    wait_ready_a(256);
    fetch_a(8'h20);
    fetch_a(8'h21);
    fetch_a(8'h10);
    fetch_a(8'hFE);
    fetch_a(8'h00);
    tick();
    check("final_q", q.size(), 0);
    done_a = 1;
  end

  task automatic fetch_b(input logic [7:0] ad,
                         input logic [15:0] d,
                         input logic e);
    b.fetch_req = 1;
    b.fetch_addr = ad;
    tick();
    b.fetch_req = 0;
    check("b_fv", 32'(b.fetch_valid), 1);
    check("b_fd", 32'(b.fetch_data), 32'(d));
    check("b_err", 32'(b.addr_err), 32'(e));
  endtask

  task automatic load_b(input logic [7:0] base,
                        input logic [15:0] w[$]);
    b.ld_start = 1;
    b.ld_base = base;
    b.ld_len = 9'(w.size());
    tick();
    b.ld_start = 0;
    foreach (w[i]) begin
      b.ld_valid = 1;
      b.ld_data = w[i];
      tick();
    end
    b.ld_valid = 0;
    check("b_ld_done", 32'(b.ld_done), 1);
  endtask

  initial begin
    int n = 0;
    idle_b();
    #2 rst_b = 0;
    #10 check("b_rst_ready", 32'(b.ready), 0);
    @(negedge clk) rst_b = 1;
    while (!b.ready && n < 400) begin
      tick();
      n++;
    end
    check("sweep_b", n, 200);

    fetch_b(8'hC8, 16'h0000, 1'b1);
    tick();
    check("b_err_pulse", 32'(b.addr_err), 0);
    check("b_fv_lo", 32'(b.fetch_valid), 0);
    fetch_b(8'hC7, 16'h0000, 1'b0);

    b.ld_start = 1;
    b.fetch_req = 1;
    b.fetch_addr = 8'h05;
    b.ld_len = '0;
    tick();
    b.ld_start = 0;
    b.fetch_req = 0;
    check("b_drop_fv", 32'(b.fetch_valid), 0);
    check("b_in_load", 32'(b.ready), 0);
    check("b_len0_done", 32'(b.ld_done), 1);
    check("b_len0_rdy", 32'(b.ld_ready), 0);
    tick();
    check("b_back_run", 32'(b.ready), 1);
    check("b_done_lo", 32'(b.ld_done), 0);

    load_b(8'hC7, '{16'h1111, 16'h2222});
    tick();
    load_b(8'hD0, '{16'h3333});
    tick();
    fetch_b(8'hC7, 16'h1111, 1'b0);
    fetch_b(8'h00, 16'h2222, 1'b0);
    fetch_b(8'h08, 16'h3333, 1'b0);
    fetch_b(8'hFF, 16'h0000, 1'b1);
    done_b = 1;
  end

  initial begin
    fork
      wait (done_a && done_b);
      #2_000_000;
    join_any
    if (!(done_a && done_b)) begin
      checks++;
      failures++;
      $display("FAIL timeout done_a=%0d done_b=%0d",
               done_a, done_b);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
